// File: rtl/motor_pkg.sv
// Shared motor-lab definitions: sequencer state encoding and H-bridge drive codes.
package motor_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_RUN   = 2'd2,
    ST_BRAKE = 2'd3
  } motor_state_t;

  localparam logic [1:0] DRV_CW  = 2'b10;
  localparam logic [1:0] DRV_CCW = 2'b01;
  localparam logic [1:0] DRV_OFF = 2'b00;

  // Map a direction bit to its bridge code; can never yield 2'b11.
  function automatic logic [1:0] drv_for(input logic dir);
    return dir ? DRV_CCW : DRV_CW;
  endfunction

endpackage

// File: rtl/dc_motor_dir_sequencer_if.sv
// Control/status bundle between a motor controller and the direction sequencer.
interface dc_motor_dir_sequencer_if;

  logic       run;
  logic       select_direction;
  logic       pwm_in;
  logic [1:0] motor_driver_inputs;
  logic       motor_enable;
  logic       busy;
  logic       cur_direction;

  modport master (
    output run, select_direction, pwm_in,
    input  motor_driver_inputs, motor_enable, busy, cur_direction
  );

  modport slave (
    input  run, select_direction, pwm_in,
    output motor_driver_inputs, motor_enable, busy, cur_direction
  );

endinterface

// File: rtl/dwell_timer.sv
// Down-counter for state dwells: load P-1 on entry, zero_c marks the last cycle.
module dwell_timer #(
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [CNT_W-1:0] load_value,
  output logic             zero_c
);

  logic [CNT_W-1:0] count;

  always_ff @(posedge clk or posedge reset) begin
    if (reset)              count <= '0;
    else if (load)          count <= load_value;
    else if (count != '0)   count <= count - CNT_W'(1);
  end

  assign zero_c = (count == '0);

endmodule

// File: rtl/dc_motor_dir_sequencer.sv
// H-bridge direction sequencer: dead-time before every enable, dynamic brake on
// stop or reversal, so the bridge direction never changes while it is energised.
module dc_motor_dir_sequencer
  import motor_pkg::*;
#(
  parameter int unsigned DEADTIME_CYCLES = 12000,
  parameter int unsigned BRAKE_CYCLES    = 24000,
  parameter int unsigned CNT_W           = 16
) (
  input  logic                    clk,
  input  logic                    reset,
  dc_motor_dir_sequencer_if.slave bus
);

  localparam logic [CNT_W-1:0] DEAD_LOAD  = CNT_W'(DEADTIME_CYCLES - 1);
  localparam logic [CNT_W-1:0] BRAKE_LOAD = CNT_W'(BRAKE_CYCLES - 1);

  motor_state_t     state_q, state_d;
  logic             dir_q, dir_d;
  logic             timer_load_c;
  logic [CNT_W-1:0] timer_value_c;
  logic             timer_zero_c;
  logic             abort_c;

  logic [1:0]       drv_q, drv_d;
  logic             en_q, en_d;
  logic             busy_q, busy_d;

  dwell_timer #(.CNT_W(CNT_W)) u_dwell_timer (
    .clk        (clk),
    .reset      (reset),
    .load       (timer_load_c),
    .load_value (timer_value_c),
    .zero_c     (timer_zero_c)
  );

  // State, latched direction and registered outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      dir_q   <= 1'b0;
      drv_q   <= DRV_OFF;
      en_q    <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      dir_q   <= dir_d;
      drv_q   <= drv_d;
      en_q    <= en_d;
      busy_q  <= busy_d;
    end
  end

  assign abort_c = !bus.run || (bus.select_direction != dir_q);

  // Next-state, direction latch and dwell-timer loading.
  always_comb begin
    state_d       = state_q;
    dir_d         = dir_q;
    timer_load_c  = 1'b0;
    timer_value_c = DEAD_LOAD;
    unique case (state_q)
      ST_IDLE: begin
        if (bus.run) begin
          state_d       = ST_START;
          dir_d         = bus.select_direction;
          timer_load_c  = 1'b1;
          timer_value_c = DEAD_LOAD;
        end
      end
      ST_START: begin
        if (abort_c)           state_d = ST_IDLE;
        else if (timer_zero_c) state_d = ST_RUN;
      end
      ST_RUN: begin
        if (abort_c) begin
          state_d       = ST_BRAKE;
          timer_load_c  = 1'b1;
          timer_value_c = BRAKE_LOAD;
        end
      end
      ST_BRAKE: begin
        if (timer_zero_c) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Output values for the state being entered, registered alongside it.
  always_comb begin
    drv_d  = DRV_OFF;
    en_d   = 1'b0;
    busy_d = 1'b0;
    unique case (state_d)
      ST_START: begin
        drv_d  = drv_for(dir_d);
        busy_d = 1'b1;
      end
      ST_RUN: begin
        drv_d = drv_for(dir_d);
        en_d  = bus.pwm_in;
      end
      ST_BRAKE: begin
        en_d   = 1'b1;
        busy_d = 1'b1;
      end
      default: ;
    endcase
  end

  assign bus.motor_driver_inputs = drv_q;
  assign bus.motor_enable        = en_q;
  assign bus.busy                = busy_q;
  assign bus.cur_direction       = dir_q;

endmodule
